// File: rtl/dp_pkg.sv
// ============================================================================
//  Module  : dp_pkg
//  Brief   : Shared opcodes, strobe indices and sequencer state encoding for
//            the accumulator datapath control sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dp_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_SUBI = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;

    localparam int NUM_STROBES  = 12;
    localparam int SB_LOAD_ACCU = 0;
    localparam int SB_ARITH_MEM = 1;
    localparam int SB_ADD       = 2;
    localparam int SB_ADDI      = 3;
    localparam int SB_SUB       = 4;
    localparam int SB_SUBI      = 5;
    localparam int SB_AND       = 6;
    localparam int SB_OR        = 7;
    localparam int SB_XOR       = 8;
    localparam int SB_NOT       = 9;
    localparam int SB_SHL       = 10;
    localparam int SB_SHR       = 11;

    typedef logic [NUM_STROBES-1:0] strobe_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_MREQ   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic strobe_t strobe_bit(input int idx);
        return strobe_t'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_seq_decode.sv
// ============================================================================
//  Module  : dp_seq_decode
//  Brief   : Combinational opcode decoder: one-hot op strobe, memory-operand
//            flag and illegal-opcode flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dp_seq_decode
    import dp_pkg::*;
(
    input  logic [3:0] opcode,
    output strobe_t    op_strobes,
    output logic       needs_mem,
    output logic       is_illegal
);

    always_comb begin
        op_strobes = '0;
        needs_mem  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_LDA:  op_strobes = strobe_bit(SB_LOAD_ACCU);
            OP_ADD:  begin op_strobes = strobe_bit(SB_ADD); needs_mem = 1'b1; end
            OP_ADDI: op_strobes = strobe_bit(SB_ADDI);
            OP_SUB:  begin op_strobes = strobe_bit(SB_SUB); needs_mem = 1'b1; end
            OP_SUBI: op_strobes = strobe_bit(SB_SUBI);
            OP_AND:  begin op_strobes = strobe_bit(SB_AND); needs_mem = 1'b1; end
            OP_OR:   begin op_strobes = strobe_bit(SB_OR);  needs_mem = 1'b1; end
            OP_XOR:  begin op_strobes = strobe_bit(SB_XOR); needs_mem = 1'b1; end
            OP_NOT:  begin op_strobes = strobe_bit(SB_NOT); needs_mem = 1'b1; end
            OP_SHL:  begin op_strobes = strobe_bit(SB_SHL); needs_mem = 1'b1; end
            OP_SHR:  begin op_strobes = strobe_bit(SB_SHR); needs_mem = 1'b1; end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dp_seq.sv
// ============================================================================
//  Module  : dp_seq
//  Brief   : Control sequencer for the 8-bit accumulator datapath. Accepts one
//            instruction, fetches a memory operand if needed, and issues the
//            datapath strobes one per cycle. Optional: DP_SEQ_TIMEOUT_EN
//            bounds the mem_ack wait and reports a timeout as illegal.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dp_seq
    import dp_pkg::*;
#(
    parameter logic [7:0] MEM_BASE    = 8'hF0,
    parameter int         TIMEOUT_CYC = 15
)(
    input  logic       clka,
    input  logic       restart,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    output logic       in_load_accu,
    output logic       in_arithMemory,
    output logic       in_add,
    output logic       in_addi,
    output logic       in_sub,
    output logic       in_subi,
    output logic       in_and,
    output logic       in_or,
    output logic       in_xor,
    output logic       in_not,
    output logic       shiftl,
    output logic       shiftr,
    output logic       in_imm,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_instr;
    strobe_t    r_strobes;
    strobe_t    w_strobes_next;
    strobe_t    w_op_strobes;
    logic       w_needs_mem;
    logic       w_is_illegal;
    logic       w_timeout;

    dp_seq_decode u_decode (
        .opcode     (r_instr[7:4]),
        .op_strobes (w_op_strobes),
        .needs_mem  (w_needs_mem),
        .is_illegal (w_is_illegal)
    );

`ifdef DP_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Held at zero outside MREQ, so every MREQ entry starts a fresh count.
    always_ff @(posedge clka or posedge restart) begin
        if (restart)
            r_wait_cnt <= '0;
        else if (r_state != ST_MREQ)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end

    assign w_timeout = (r_state == ST_MREQ) && !mem_ack &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign w_timeout            = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (instr_valid) w_state_next = ST_DECODE;
            ST_DECODE: begin
                if (w_is_illegal)             w_state_next = ST_DONE;
                else if (w_needs_mem)         w_state_next = ST_MREQ;
                else if (w_op_strobes != '0)  w_state_next = ST_EXEC;
                else                          w_state_next = ST_DONE;
            end
            ST_MREQ: begin
                if (mem_ack)        w_state_next = ST_LOAD;
                else if (w_timeout) w_state_next = ST_DONE;
            end
            ST_LOAD:   w_state_next = ST_EXEC;
            ST_EXEC:   w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_strobes_next = '0;
        if (w_state_next == ST_LOAD)
            w_strobes_next = strobe_bit(SB_ARITH_MEM);
        else if (w_state_next == ST_EXEC)
            w_strobes_next = w_op_strobes;
    end

    // Outputs are registered from the next state so each one lines up
    // exactly with the state it belongs to.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_strobes   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_strobes <= w_strobes_next;
            if (r_state == ST_IDLE && instr_valid)
                r_instr <= instr;
            if (r_state == ST_DECODE && w_state_next == ST_MREQ)
                mem_addr <= MEM_BASE + {4'h0, r_instr[3:0]};
            mem_req     <= (w_state_next == ST_MREQ);
            busy        <= (w_state_next != ST_IDLE);
            instr_ready <= (w_state_next == ST_IDLE);
            done        <= (w_state_next == ST_DONE);
            illegal     <= (w_state_next == ST_DONE) && (w_is_illegal || w_timeout);
        end
    end

    assign in_imm         = r_instr[0];
    assign in_load_accu   = r_strobes[SB_LOAD_ACCU];
    assign in_arithMemory = r_strobes[SB_ARITH_MEM];
    assign in_add         = r_strobes[SB_ADD];
    assign in_addi        = r_strobes[SB_ADDI];
    assign in_sub         = r_strobes[SB_SUB];
    assign in_subi        = r_strobes[SB_SUBI];
    assign in_and         = r_strobes[SB_AND];
    assign in_or          = r_strobes[SB_OR];
    assign in_xor         = r_strobes[SB_XOR];
    assign in_not         = r_strobes[SB_NOT];
    assign shiftl         = r_strobes[SB_SHL];
    assign shiftr         = r_strobes[SB_SHR];

endmodule

`default_nettype wire

// File: doc/dp_seq.md
Name: dp_seq

Overview:
- Control sequencer directly upstream of the 8-bit accumulator datapath.
- Accepts one 8-bit instruction at a time over a valid/ready handshake and decodes it.
- For register-operand ops, fetches the operand via a request/acknowledge memory handshake.
- Emits the datapath's one-hot control strobes in the correct order, then signals completion.

Parameters:
- MEM_BASE, 8'hF0, base address added to the instruction's 4-bit operand field to form mem_addr.
- TIMEOUT_CYC, 15, maximum mem_ack wait in cycles; used only when DP_SEQ_TIMEOUT_EN is defined.

Ports:
- clka  in  1  single clock; all state updates on rising edge.
- restart  in  1  asynchronous active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  8  [7:4] opcode, [3:0] operand address offset or immediate.
- instr_ready  out  1  sequencer can accept an instruction.
- mem_req  out  1  operand read request.
- mem_addr  out  8  operand address.
- mem_ack  in  1  operand present on datapath reg_in this cycle.
- in_load_accu, in_arithMemory, in_add, in_addi, in_sub, in_subi, in_and, in_or, in_xor, in_not, shiftl, shiftr  out  1 each  datapath strobes.
- in_imm  out  1  immediate bit to datapath (= latched instr[0]).
- busy  out  1  instruction in flight.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse coincident with done for opcodes C-F.

Behaviour:
- Reset (async, while restart=1): state IDLE; all strobes, mem_req, done, illegal, busy = 0; mem_addr=0; in_imm=0; instruction latch=0.
- All outputs are registered. Each strobe is held for exactly one full clka cycle, so the datapath's falling-edge sample sees it exactly once.
- At most one strobe is high in any cycle.
- Opcodes:
  - 0 NOP.
  - 1 LDA: in_load_accu.
  - 2 ADD, 4 SUB, 6 AND, 7 OR, 8 XOR, 9 NOT, A SHL (shiftl), B SHR (shiftr): memory-operand ops.
  - 3 ADDI, 5 SUBI: immediate ops.
  - C-F: illegal.
- States:
  - IDLE: instr_ready=1. On instr_valid, latch instr and go to DECODE.
  - DECODE:
    - Memory-operand op: go to MREQ, with mem_addr = (MEM_BASE + instr[3:0]) mod 256.
    - LDA, ADDI, SUBI: go to EXEC.
    - NOP, illegal: go to DONE.
  - MREQ: mem_req=1, held until mem_ack sampled high; then mem_req drops next edge and go to LOAD. If mem_ack is already high on the first MREQ cycle, leave MREQ after one cycle.
  - LOAD: in_arithMemory=1 for one cycle; go to EXEC.
  - EXEC: the decoded op strobe=1 for one cycle; in_imm valid here. Go to DONE.
  - DONE: done=1 (illegal=1 if opcode C-F); return to IDLE.
- busy=1 in every state except IDLE.
- instr_ready=0 outside IDLE; instr_valid outside IDLE is ignored (no queueing).
- Latency from the accepting edge to the done pulse:
  - Memory-operand op with immediate ack: 5 cycles (DECODE, MREQ, LOAD, EXEC, DONE).
  - LDA/ADDI/SUBI: 3 cycles.
  - NOP/illegal: 2 cycles.
- mem_ack outside MREQ is ignored.
- Back-to-back: instr_ready is reasserted in the cycle after done, so a new instruction can be accepted one cycle after DONE.
- Restart mid-operation: everything clears immediately, including any active strobe or mem_req. No done pulse is produced for the aborted instruction.

Optional Feature:
- Macro: DP_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter counts MREQ cycles.
  - When TIMEOUT_CYC cycles pass without mem_ack, drop mem_req and go to DONE with done=1 and illegal=1. No in_arithMemory or op strobe is issued.
  - The counter clears on entry to MREQ and on restart.
- Undefined: MREQ waits indefinitely; no counter is instantiated.

Decomposition:
- Shared package dp_pkg:
  - Opcode constants OP_NOP..OP_SHR.
  - State enum: IDLE, DECODE, MREQ, LOAD, EXEC, DONE.
  - Strobe-vector bit indices.
- Natural sub-module: dp_seq_decode, purely combinational. It maps opcode to strobe vector, needs_mem and is_illegal.

Test Plan:
- ADD at 0x25 (MEM_BASE=F0), mem_ack 1 cycle after mem_req -> mem_addr=F5; in_arithMemory then in_add, each one cycle; done 6 cycles after accept; never two strobes high at once.
- ADDI 0x31 -> no mem_req; in_addi with in_imm=1 in EXEC; done 3 cycles after accept.
- LDA then SHR (0x1x, 0xB3) back-to-back, instr_valid held high -> second instruction accepted the cycle after the first done; shiftr pulse once; mem_addr=F3.
- Illegal 0xE7 -> no strobe, no mem_req; done and illegal pulse together 2 cycles after accept.
- Restart asserted during MREQ with mem_req=1 -> mem_req and busy drop asynchronously; no done; next instruction completes normally.
- With DP_SEQ_TIMEOUT_EN and TIMEOUT_CYC=4, SUB with mem_ack never asserted -> mem_req high for 4 cycles; then done and illegal pulse; no in_sub.
